rsa_modexp_ctrl: RTL and testbench
==================================

Name: rsa_modexp_ctrl

Overview:
Sequencer that computes C = M^E mod P on a shared Montgomery modular multiplier using left-to-right square-and-multiply. It takes operands and start/stop pulses from the SPI register bank. It returns the result with a one-cycle eoc pulse, which the register bank captures into its C register. The multiplier itself is external; this block only issues operations and steers operands and results.

Parameters:
WIDTH, 8, operand/modulus width; Montgomery R = 2^WIDTH
CNT_W, $clog2(WIDTH), exponent bit-index counter width (derived, not overridden)

Ports:
clk  input  1  clock
rstb  input  1  reset (already decided)
ena  input  1  global enable; all state updates gated by ena
start  input  1  one-cycle start pulse
stop  input  1  one-cycle abort pulse
p  input  WIDTH  modulus; must be odd
e  input  WIDTH  exponent
m  input  WIDTH  message; must be < p
r2  input  WIDTH  Montgomery constant R^2 mod p
mm_start  output  1  multiplier issue pulse
mm_a  output  WIDTH  multiplier operand A
mm_b  output  WIDTH  multiplier operand B
mm_p  output  WIDTH  multiplier modulus (latched p)
mm_done  input  1  multiplier result valid, one-cycle pulse
mm_res  input  WIDTH  multiplier result a*b*R^-1 mod p
c  output  WIDTH  result
eoc  output  1  end-of-computation pulse
busy  output  1  high in any state except IDLE

Behaviour:
- Reset: state IDLE; c, mm_a, mm_b, mm_p = 0; mm_start, eoc, busy = 0; internal regs (x, mbar, e_q, idx) = 0.
- ena=0: state and registers hold; mm_start and eoc forced 0. A pending issue or eoc is delivered on the next ena=1 cycle. mm_done is sampled only when ena=1.
- Operation handshake: mm_start high exactly one enabled cycle. mm_a, mm_b, mm_p are stable from that cycle until mm_done. mm_res is captured on the edge where mm_done=1. The next mm_start comes in the following cycle. mm_done outside a WAIT state is ignored.
- States: IDLE, LOAD, CONV_M, CONV_X, SQR, MUL, FIN, ABORT, DONE. Each op state issues, then waits for mm_done.
- IDLE: start=1 and stop=0 -> LOAD. start while busy is ignored.
- LOAD (1 cycle): latch p, e, m, r2 into e_q and operand regs; idx = WIDTH-1 -> CONV_M.
- CONV_M: mbar = MM(m, r2) -> CONV_X.
- CONV_X: x = MM(1, r2), which gives R mod p -> SQR.
- SQR: x = MM(x, x). If e_q[idx]=1 -> MUL. Otherwise: if idx=0 -> FIN, else idx-1 and -> SQR.
- MUL: x = MM(x, mbar). Then: if idx=0 -> FIN, else idx-1 and -> SQR.
- FIN: c = MM(x, 1) -> DONE.
- DONE (1 cycle): c updated on entry; eoc=1 for this cycle only -> IDLE. busy drops the cycle after eoc.
- Op count: 3 + WIDTH + popcount(e). For a multiplier latency of L cycles, total latency = 1 (LOAD) + ops*(L+1) + 1 (DONE).
- stop while busy: no further mm_start is issued.
  - If an op is in flight -> ABORT until mm_done, then IDLE.
  - Otherwise -> IDLE next cycle.
  - c is unchanged and eoc is not pulsed.
- stop and start in the same cycle: stop wins.
- Input changes on p, e, m, r2 during a computation have no effect (operands are latched).
- e=0 -> c = 1. m=0, e≠0 -> c = 0.
- Operands must satisfy p odd, m < p, r2 correct. The block does not check these; results are undefined otherwise.
- Reset mid-operation: immediate return to reset values. The multiplier is reset by the same rstb.

Optional Feature:
RSA_MODEXP_SKIP_LZ_EN
- Defined: LOAD sets idx to the index of the MSB set in e. If e=0, LOAD goes directly to FIN with x = R mod p, which requires CONV_X to run; the path is LOAD -> CONV_M -> CONV_X -> FIN.
- Defined op count: 3 + (msb_index+1) + popcount(e), or 3 for e=0.
- Not defined: all WIDTH exponent bits are processed, giving fixed square count and timing. Results are identical either way.

Test Plan:
- Bench model: behavioural Montgomery multiplier with L=4; WIDTH=8.
- p=13, r2=3, m=5, e=3, start -> c=8, one eoc pulse. 13 mm_start pulses without the macro, 7 with it. Total cycles 1+13*5+1=67 without the macro.
- p=13, r2=3, m=5, e=0 -> c=1. m=0, e=5 -> c=0.
- Run p=13, m=5, e=3 (c=8). Then start again with e=2; pulse stop during the 3rd op wait -> one mm_done consumed, no further mm_start, no eoc, c stays 8, busy low the cycle after mm_done.
- start re-pulsed 5 times while busy, plus start and stop together in IDLE -> mm_start count unchanged, state stays in its sequence or IDLE.
- ena held low 10 cycles mid-SQR wait, with mm_done arriving while ena=0 and held until ena=1 -> completion delayed by exactly 10 cycles, c=8.
- rstb asserted in MUL state -> all outputs 0 immediately. Subsequent start yields correct c.

Source files
------------

// File: rtl/rsa_modexp_ctrl.sv
// rsa_modexp_ctrl: sequencer for C = M^E mod P using left-to-right square-and-multiply on an
// external, shared Montgomery multiplier (MM(a,b) = a*b*R^-1 mod p, R = 2^WIDTH).
//
// Ports:
//   clk, rstb           clock, asynchronous active-low reset
//   ena                 global enable; every state update is gated by it
//   start, stop         one-cycle start / abort pulses (stop wins)
//   p, e, m, r2         modulus, exponent, message, R^2 mod p (latched on start)
//   mm_start            multiplier issue pulse
//   mm_a, mm_b, mm_p    multiplier operands, stable from issue until mm_done
//   mm_done, mm_res     multiplier result strobe and value
//   c, eoc              result and one-cycle end-of-computation pulse
//   busy                high whenever the sequencer is not idle
//
// Build option: define RSA_MODEXP_SKIP_LZ_EN to skip the exponent's leading zero bits.
// Results are identical either way; only op count and timing change.
module rsa_modexp_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             ena,
  input  logic             start,
  input  logic             stop,
  input  logic [WIDTH-1:0] p,
  input  logic [WIDTH-1:0] e,
  input  logic [WIDTH-1:0] m,
  input  logic [WIDTH-1:0] r2,
  output logic             mm_start,
  output logic [WIDTH-1:0] mm_a,
  output logic [WIDTH-1:0] mm_b,
  output logic [WIDTH-1:0] mm_p,
  input  logic             mm_done,
  input  logic [WIDTH-1:0] mm_res,
  output logic [WIDTH-1:0] c,
  output logic             eoc,
  output logic             busy
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] IdxMax = CNT_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] One = WIDTH'(1);

  typedef enum logic [3:0] {
    StIdle, StLoad, StConvM, StConvX, StSqr, StMul, StFin, StAbort, StDone
  } state_e;

  state_e           state_q, state_d;
  logic             wait_q, wait_d;    // op issued, waiting for mm_done
  logic [WIDTH-1:0] p_q, p_d;
  logic [WIDTH-1:0] e_q, e_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic [WIDTH-1:0] r2_q, r2_d;
  logic [WIDTH-1:0] x_q, x_d;
  logic [WIDTH-1:0] mbar_q, mbar_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] c_q, c_d;
  logic [WIDTH-1:0] mm_a_q, mm_a_d;
  logic [WIDTH-1:0] mm_b_q, mm_b_d;
  logic             load_ops;          // state_d is a fresh op: set up its operands
  logic             is_op;
  logic [CNT_W-1:0] start_idx;

`ifdef RSA_MODEXP_SKIP_LZ_EN
  function automatic logic [CNT_W-1:0] msb_index(input logic [WIDTH-1:0] v);
    logic [CNT_W-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (v[i]) r = CNT_W'(i);
    end
    return r;
  endfunction

  assign start_idx = msb_index(e_q);
`else
  assign start_idx = IdxMax;
`endif

  assign is_op = (state_q == StConvM) || (state_q == StConvX) || (state_q == StSqr) ||
                 (state_q == StMul) || (state_q == StFin);

  // stop suppresses an issue that would otherwise happen in the same cycle
  assign mm_start = ena && is_op && !wait_q && !stop;
  assign eoc      = ena && (state_q == StDone);
  assign busy     = (state_q != StIdle);
  assign c        = c_q;
  assign mm_a     = mm_a_q;
  assign mm_b     = mm_b_q;
  assign mm_p     = p_q;

  always_comb begin
    state_d  = state_q;
    wait_d   = wait_q;
    p_d      = p_q;
    e_d      = e_q;
    m_d      = m_q;
    r2_d     = r2_q;
    x_d      = x_q;
    mbar_d   = mbar_q;
    idx_d    = idx_q;
    c_d      = c_q;
    mm_a_d   = mm_a_q;
    mm_b_d   = mm_b_q;
    load_ops = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start && !stop) begin
          p_d     = p;
          e_d     = e;
          m_d     = m;
          r2_d    = r2;
          state_d = StLoad;
        end
      end
      StLoad: begin
        if (stop) begin
          state_d = StIdle;
        end else begin
          idx_d    = start_idx;
          state_d  = StConvM;
          load_ops = 1'b1;
        end
      end
      StConvM, StConvX, StSqr, StMul, StFin: begin
        if (stop) begin
          // an op in flight must still drain its mm_done before we go idle
          state_d = (wait_q && !mm_done) ? StAbort : StIdle;
          wait_d  = 1'b0;
        end else if (!wait_q) begin
          wait_d = 1'b1;
        end else if (mm_done) begin
          wait_d   = 1'b0;
          load_ops = 1'b1;
          case (state_q)
            StConvM: begin
              mbar_d  = mm_res;
              state_d = StConvX;
            end
            StConvX: begin
              x_d     = mm_res;
`ifdef RSA_MODEXP_SKIP_LZ_EN
              // e = 0: x already holds R mod p, i.e. Montgomery form of 1
              state_d = (e_q == '0) ? StFin : StSqr;
`else
              state_d = StSqr;
`endif
            end
            StSqr: begin
              x_d = mm_res;
              if (e_q[idx_q]) begin
                state_d = StMul;
              end else if (idx_q == '0) begin
                state_d = StFin;
              end else begin
                idx_d   = idx_q - 1'b1;
                state_d = StSqr;
              end
            end
            StMul: begin
              x_d = mm_res;
              if (idx_q == '0) begin
                state_d = StFin;
              end else begin
                idx_d   = idx_q - 1'b1;
                state_d = StSqr;
              end
            end
            StFin: begin
              c_d      = mm_res;
              state_d  = StDone;
              load_ops = 1'b0;
            end
            default: ;
          endcase
        end
      end
      StAbort: begin
        if (mm_done) state_d = StIdle;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Operands are registered on entry so they stay stable through the whole wait.
    if (load_ops) begin
      case (state_d)
        StConvM: begin
          mm_a_d = m_q;
          mm_b_d = r2_q;
        end
        StConvX: begin
          mm_a_d = One;
          mm_b_d = r2_q;
        end
        StSqr: begin
          mm_a_d = x_d;
          mm_b_d = x_d;
        end
        StMul: begin
          mm_a_d = x_d;
          mm_b_d = mbar_d;
        end
        StFin: begin
          mm_a_d = x_d;
          mm_b_d = One;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q <= StIdle;
      wait_q  <= 1'b0;
      p_q     <= '0;
      e_q     <= '0;
      m_q     <= '0;
      r2_q    <= '0;
      x_q     <= '0;
      mbar_q  <= '0;
      idx_q   <= '0;
      c_q     <= '0;
      mm_a_q  <= '0;
      mm_b_q  <= '0;
    end else if (ena) begin
      state_q <= state_d;
      wait_q  <= wait_d;
      p_q     <= p_d;
      e_q     <= e_d;
      m_q     <= m_d;
      r2_q    <= r2_d;
      x_q     <= x_d;
      mbar_q  <= mbar_d;
      idx_q   <= idx_d;
      c_q     <= c_d;
      mm_a_q  <= mm_a_d;
      mm_b_q  <= mm_b_d;
    end
  end

endmodule

// File: tb/tb_rsa_modexp_ctrl.sv
// Self-checking bench for rsa_modexp_ctrl (WIDTH=8) with a behavioural Montgomery multiplier of
// latency 4. Expected results come from a plain modular-exponentiation model via a scoreboard.
module tb_rsa_modexp_ctrl;

  localparam int L = 4;

  logic       clk = 1'b0;
  logic       rstb, ena, start, stop;
  logic [7:0] p, e, m, r2;
  logic       mm_start, mm_done, eoc, busy;
  logic [7:0] mm_a, mm_b, mm_p, mm_res, c;

  int cyc = 0;
  int st_cnt = 0, eoc_cnt = 0, eoc_cyc = 0, last_st_cyc = 0;
  int start_cyc = 0, base_st = 0, base_eoc = 0, exp_ops = 0;
  int total = 0, passed = 0;
  int exp_q[$];
  bit stab_bad = 1'b0;

  rsa_modexp_ctrl #(.WIDTH(8)) dut (
    .clk(clk), .rstb(rstb), .ena(ena), .start(start), .stop(stop),
    .p(p), .e(e), .m(m), .r2(r2),
    .mm_start(mm_start), .mm_a(mm_a), .mm_b(mm_b), .mm_p(mm_p),
    .mm_done(mm_done), .mm_res(mm_res),
    .c(c), .eoc(eoc), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] mont(input logic [7:0] a, input logic [7:0] b,
                                      input logic [7:0] pp);
    int u;
    u = 0;
    for (int i = 0; i < 8; i++) begin
      if (a[i]) u += int'(b);
      if (u % 2 == 1) u += int'(pp);
      u = u / 2;
    end
    if (u >= int'(pp)) u -= int'(pp);
    return 8'(u);
  endfunction

  function automatic int modexp(input int mm, input int ee, input int pp);
    int r;
    r = 1 % pp;
    for (int i = 7; i >= 0; i--) begin
      r = (r * r) % pp;
      if (ee[i]) r = (r * mm) % pp;
    end
    return r;
  endfunction

  function automatic int ops_for(input int ee);
    int pc, msb;
    pc = 0;
    msb = -1;
    for (int i = 0; i < 8; i++) if (ee[i]) begin pc++; msb = i; end
`ifdef RSA_MODEXP_SKIP_LZ_EN
    return (ee == 0) ? 3 : 3 + msb + 1 + pc;
`else
    return 3 + 8 + pc;
`endif
  endfunction

  // Behavioural multiplier; a finished result is held while ena is low.
  int         mcnt;
  logic [7:0] ca, cb, cp;
  always @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      mm_done <= 1'b0;
      mm_res  <= '0;
      mcnt    <= 0;
    end else begin
      if (mm_done && ena) mm_done <= 1'b0;
      if (mcnt > 0) begin
        if (mm_a !== ca || mm_b !== cb || mm_p !== cp || mm_start) stab_bad <= 1'b1;
        if (mcnt == 1) begin
          mm_done <= 1'b1;
          mm_res  <= mont(ca, cb, cp);
        end
        mcnt <= mcnt - 1;
      end else if (mm_start) begin
        ca   <= mm_a;
        cb   <= mm_b;
        cp   <= mm_p;
        mcnt <= L - 1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) passed++;
    else $error("FAIL %s: got %0d expected %0d", tag, obs, expv);
  endtask

  // Monitor: count issues and eoc pulses, compare c against the scoreboard.
  always @(negedge clk) begin
    if (rstb) begin
      if (mm_start) begin
        st_cnt++;
        last_st_cyc = cyc;
      end
      if (eoc) begin
        eoc_cnt++;
        eoc_cyc = cyc;
        if (exp_q.size() == 0) chk("eoc_expected", exp_q.size(), 1);
        else chk("c_result", 32'(c), exp_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_to(input int target);
    for (int k = 0; k < 200 && cyc < target; k++) tick();
  endtask

  task automatic wait_starts(input int n);
    for (int k = 0; k < 3000 && st_cnt < n; k++) tick();
    chk("issue_seen", 32'(st_cnt >= n), 1);
  endtask

  task automatic wait_eoc(input int n);
    for (int k = 0; k < 3000 && eoc_cnt < n; k++) tick();
    chk("eoc_arrived", 32'(eoc_cnt >= n), 1);
  endtask

  task automatic begin_run(input int pp, input int ee, input int mm, input bit push);
    p = 8'(pp);
    e = 8'(ee);
    m = 8'(mm);
    r2 = 8'(65536 % pp);
    base_st = st_cnt;
    base_eoc = eoc_cnt;
    exp_ops = ops_for(ee);
    if (push) exp_q.push_back(modexp(mm, ee, pp));
    start = 1'b1;
    start_cyc = cyc;
    tick();
    start = 1'b0;
    // operands are latched; scrambling the inputs must not matter
    p = 8'($urandom);
    e = 8'($urandom);
    m = 8'($urandom);
    r2 = 8'($urandom);
  endtask

  task automatic end_run(input int extra);
    wait_eoc(base_eoc + 1);
    chk("busy_after_eoc", 32'(busy), 0);
    chk("latency", eoc_cyc - start_cyc, 2 + exp_ops * (L + 1) + extra);
    chk("op_count", st_cnt - base_st, exp_ops);
    tick();
    tick();
    chk("eoc_count", eoc_cnt - base_eoc, 1);
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_c"}, 32'(c), 0);
    chk({tag, "_mm_a"}, 32'(mm_a), 0);
    chk({tag, "_mm_b"}, 32'(mm_b), 0);
    chk({tag, "_mm_p"}, 32'(mm_p), 0);
    chk({tag, "_mm_start"}, 32'(mm_start), 0);
    chk({tag, "_eoc"}, 32'(eoc), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int plist[5];
    int pp, sb, se;
    plist = '{3, 11, 13, 97, 251};
    rstb = 1'b0; ena = 1'b1; start = 1'b0; stop = 1'b0;
    p = '0; e = '0; m = '0; r2 = '0;
    tick();
    tick();
    check_zero_outputs("reset");
    rstb = 1'b1;
    tick();

    // Main function: directed and random operands
    begin_run(13, 3, 5, 1'b1);
    end_run(0);
    begin_run(13, 0, 5, 1'b1);
    end_run(0);
    begin_run(13, 5, 0, 1'b1);
    end_run(0);
    for (int i = 0; i < 4; i++) begin
      pp = plist[$urandom_range(0, 4)];
      begin_run(pp, int'($urandom_range(0, 255)), int'($urandom_range(0, pp - 1)), 1'b1);
      end_run(0);
    end

    // Abort during the third op wait
    begin_run(13, 3, 5, 1'b1);
    end_run(0);
    begin_run(13, 2, 5, 1'b0);
    wait_starts(base_st + 3);
    tick_to(last_st_cyc + 1);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    tick_to(last_st_cyc + L);
    chk("abort_busy_on_done", 32'(busy), 1);
    tick();
    chk("abort_busy_after_done", 32'(busy), 0);
    repeat (10) tick();
    chk("abort_no_issue", st_cnt - base_st, 3);
    chk("abort_no_eoc", eoc_cnt - base_eoc, 0);
    chk("abort_c_kept", 32'(c), 8);

    // start re-pulsed while busy, then start+stop together in idle
    begin_run(13, 3, 5, 1'b1);
    repeat (5) begin
      tick(); tick(); tick();
      start = 1'b1;
      tick();
      start = 1'b0;
    end
    end_run(0);
    sb = st_cnt;
    se = eoc_cnt;
    start = 1'b1;
    stop = 1'b1;
    tick();
    start = 1'b0;
    stop = 1'b0;
    chk("start_stop_idle_busy", 32'(busy), 0);
    repeat (5) tick();
    chk("start_stop_no_issue", st_cnt - sb, 0);
    chk("start_stop_no_eoc", eoc_cnt - se, 0);

    // ena low for 10 cycles from the cycle mm_done arrives in the first SQR
    begin_run(13, 3, 5, 1'b1);
    wait_starts(base_st + 3);
    tick_to(last_st_cyc + L);
    ena = 1'b0;
    repeat (10) tick();
    ena = 1'b1;
    end_run(10);

    // Reset while in MUL
    begin_run(13, 3, 5, 1'b0);
`ifdef RSA_MODEXP_SKIP_LZ_EN
    wait_starts(base_st + 4);
`else
    wait_starts(base_st + 10);
`endif
    tick_to(last_st_cyc + 2);
    rstb = 1'b0;
    #1;
    check_zero_outputs("mid_reset");
    tick();
    rstb = 1'b1;
    tick();
    begin_run(13, 3, 5, 1'b1);
    end_run(0);

    chk("scoreboard_empty", exp_q.size(), 0);
    chk("operand_stability", 32'(stab_bad), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
